// File: rtl/arith_pkg.sv
// Shared definitions for the modular adder/subtractor datapath stages.
package arith_pkg;

  // Default operand width and number of candidate operand pairs.
  localparam int unsigned DefWidth  = 4;
  localparam int unsigned DefNumSrc = 2;
  localparam int unsigned DefSelW   = $clog2(DefNumSrc);

  // Payload handed from the operand-select stage to the adder stage.
  typedef struct packed {
    logic [DefWidth-1:0] a;
    logic [DefWidth-1:0] b;
    logic [DefSelW-1:0]  src;
    logic                err;
  } stage_payload_t;

  // True when a select value addresses an existing candidate slot.
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_src);
    return sel < num_src;
  endfunction

endpackage

// File: rtl/operand_mux_n.sv
// Combinational NUM_SRC:1 slot selector with out-of-range flag.
module operand_mux_n import arith_pkg::*; #(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned NUM_SRC = DefNumSrc,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         y,
  output logic                     err
);

  logic [31:0] sel_ext;

  assign sel_ext = 32'(sel);

  // Pick the addressed slot; unaddressable selects yield zero and raise err.
  always_comb begin
    y   = '0;
    err = !sel_in_range(sel_ext, NUM_SRC);
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (sel_ext == k) begin
        y = data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/operand_select_stage.sv
// Registered operand select stage: NUM_SRC:1 pair mux, optional swap,
// and a 2-entry skid buffer so in_ready never depends on out_ready.
module operand_select_stage import arith_pkg::*; #(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned NUM_SRC = DefNumSrc,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_swap,
  input  logic [NUM_SRC*WIDTH-1:0] in_a,
  input  logic [NUM_SRC*WIDTH-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic [SEL_W-1:0]         out_src,
  output logic                     out_err
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SEL_W-1:0] src;
    logic             err;
  } payload_t;

  // Encoding is {M.valid, S.valid} so the valid bits fall straight out of the state.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StFull  = 2'b11
  } state_e;

  state_e   state_q, state_d;
  payload_t m_q, m_d;
  payload_t s_q, s_d;
  payload_t new_pl;

  logic [WIDTH-1:0] a_slot, b_slot;
  logic             a_err, b_err;
  logic             accept, emit;

  operand_mux_n #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_mux_a (
    .data (in_a),
    .sel  (in_sel),
    .y    (a_slot),
    .err  (a_err)
  );

  operand_mux_n #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_mux_b (
    .data (in_b),
    .sel  (in_sel),
    .y    (b_slot),
    .err  (b_err)
  );

  // Form the incoming payload: swap after selection, zeroed operands on a bad select.
  always_comb begin
    new_pl     = '0;
    new_pl.src = in_sel;
    new_pl.err = a_err | b_err;
    if (a_err | b_err) begin
      new_pl.a = '0;
      new_pl.b = '0;
    end else if (in_swap) begin
      new_pl.a = b_slot;
      new_pl.b = a_slot;
    end else begin
      new_pl.a = a_slot;
      new_pl.b = b_slot;
    end
  end

  assign in_ready  = !state_q[0];
  assign out_valid = state_q[1];
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  // Next-state and register-load decisions; registers only load on a handshake,
  // so data/sel inputs are never captured while in_valid is low.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          m_d     = new_pl;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && emit) begin
          m_d = new_pl;
        end else if (accept) begin
          s_d     = new_pl;
          state_d = StFull;
        end else if (emit) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (emit) begin
          m_d     = s_q;
          s_d     = '0;
          state_d = StOne;
        end
      end
      default: begin
        state_d = StEmpty;
      end
    endcase
  end

  // State and payload registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  assign out_a   = m_q.a;
  assign out_b   = m_q.b;
  assign out_src = m_q.src;
  assign out_err = m_q.err;

endmodule

// File: doc/operand_select_stage.md
Name: operand_select_stage

Overview:
- Parametrised, registered successor to the second-stage operand mux bank of the modular adder/subtractor datapath.
- Selects one of NUM_SRC candidate operand pairs (A,B), with optional A/B swap for the subtract path.
- Presents the result through a valid/ready 2-entry skid buffer, so the stage can sit between the first (precompute) and third (adder) stages without combinational ready paths.

Parameters:
- WIDTH, 4, bit width of each operand A and B.
- NUM_SRC, 2, number of candidate operand pairs; legal range 2..16.
- SEL_W, $clog2(NUM_SRC), select width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream transfer request.
- in_ready  out  1  stage can accept a transfer this cycle.
- in_sel  in  SEL_W  index of candidate pair to forward.
- in_swap  in  1  1 = exchange A and B after selection.
- in_a  in  NUM_SRC*WIDTH  packed candidate A operands; slot k at bits [k*WIDTH +: WIDTH].
- in_b  in  NUM_SRC*WIDTH  packed candidate B operands, same packing.
- out_valid  out  1  output holds a valid transfer.
- out_ready  in  1  downstream accepts.
- out_a  out  WIDTH  selected (possibly swapped) A.
- out_b  out  WIDTH  selected (possibly swapped) B.
- out_src  out  SEL_W  in_sel value echoed with the data.
- out_err  out  1  in_sel was >= NUM_SRC for this transfer.

Behaviour:
- Accept: in_valid && in_ready at a rising clk edge.
- Emit: out_valid && out_ready at a rising clk edge.
- Selection (combinational, before the register):
  - a_sel = in_a slot in_sel; b_sel = in_b slot in_sel.
  - If in_swap, A/B are exchanged.
  - If in_sel >= NUM_SRC (non-power-of-2 NUM_SRC only): A = B = 0 and err = 1; swap is ignored.
- Storage: main register M (drives the outputs) and skid register S; each holds {a, b, src, err, valid}.
- State machine on {M.valid, S.valid}:
  - EMPTY (0,0): accept -> load M -> ONE.
  - ONE (1,0):
    - accept and emit together -> load M with new data, stay ONE.
    - accept only -> load S -> FULL.
    - emit only -> EMPTY.
  - FULL (1,1): emit -> M <= S, S cleared -> ONE. No accept is possible.
- in_ready = !S.valid. It is registered-derived only; there is no combinational path from out_ready.
- out_valid = M.valid. out_a/out_b/out_src/out_err = M fields and are held stable while out_valid && !out_ready.
- Latency: 1 cycle from accept to out_valid when EMPTY. Sustained throughput is 1 transfer/cycle when out_ready stays high.
- Ordering: strict FIFO, no drops, no duplicates.
- Reset (async assert, any cycle including mid-transfer):
  - M.valid = S.valid = 0, so out_valid = 0 and in_ready = 1.
  - out_a = out_b = 0, out_src = 0, out_err = 0.
  - In-flight data is discarded.
  - Deassertion is assumed synchronised externally; the first accept can occur on the first edge after release.
- X-handling: data/sel inputs are don't-care when in_valid = 0 and must not propagate into state.

Decomposition:
- Shared package (arith_pkg):
  - Default WIDTH/NUM_SRC constants.
  - Typedef for the stage payload struct {a, b, src, err}, reused by the third stage.
- One natural sub-module: operand_mux_n.
  - Purely combinational NUM_SRC:1 selector of a WIDTH-bit slot plus range-error flag.
  - Instantiated twice, once for A and once for B.
  - Generalises the existing 2:1 MUX primitive; swap logic stays in the top.

Test Plan (WIDTH=4, NUM_SRC=2 unless stated):
- Basic pass: in_a={4'h3,4'h9}, in_b={4'h5,4'h1}, sel=1, swap=0, out_ready=1 -> next cycle out_valid=1, out_a=3, out_b=5, out_src=1, out_err=0.
- Swap: same inputs, sel=0, swap=1 -> out_a=1, out_b=9.
- Backpressure/skid: out_ready=0, send transfers T0 (sel=0), T1 (sel=1) on consecutive cycles -> in_ready=0 after T1; outputs hold T0. Then raise out_ready -> T0 then T1 emitted in order; in_ready returns to 1 one cycle after T0 emits.
- Streaming: 16 back-to-back transfers with out_ready=1 -> 16 outputs on consecutive cycles, in order; in_ready never drops.
- Out-of-range (NUM_SRC=3, SEL_W=2): sel=3, swap=1 -> out_a=0, out_b=0, out_err=1, out_src=3.
- Reset mid-operation: FULL state, assert rst between clock edges -> out_valid=0 and in_ready=1 immediately (asynchronously, without waiting for a clock edge), outputs 0. After release, a new transfer sel=0 -> emitted next cycle with no stale data.
